cgra_result_tx: RTL and testbench
=================================

# cgra_result_tx

Host-facing result transmitter for the 2x2 mini AIE CGRA top level. Buffers 8-bit results emitted by the tile array in a small FIFO and sends each one to the external host as a two-byte frame (header, data) over the dedicated output pins. Each byte uses a 4-phase valid/ack handshake, with the host ack arriving on an input pin. It is the outbound counterpart of the host-to-array configuration/input path and drives `uo_out` and one `uio_out` bit in the top level.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..8.
- `HDR_TAG`, 4'b1010: upper nibble of every header byte.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  design-select; low freezes the transmitter.
- `res_valid`  in  1  array result strobe.
- `res_tile`  in  2  originating tile index, 0..3.
- `res_data`  in  8  result value.
- `res_ready`  out  1  combinational: `ena & !full`.
- `host_ack`  in  1  raw host acknowledge pin; asynchronous to `clk`.
- `tx_data`  out  8  byte presented to host (`uo_out`), registered.
- `tx_valid`  out  1  byte-valid to host (`uio_out` bit), registered.
- `busy`  out  1  FSM not in IDLE, registered.
- `level`  out  4  FIFO occupancy, 0..DEPTH.

## Operation
- **Reset** (async, `rst_n`=0):
  - FIFO empty; `level`=0.
  - FSM in IDLE.
  - `tx_data`=0, `tx_valid`=0, `busy`=0.
  - Both sync flops cleared.
  - `res_ready`=1 once `ena`=1.
- **Push:** an entry {`res_tile`, `res_data`} is written on a rising edge with `res_valid & res_ready`. Pushes while full are impossible because `res_ready`=0.
- **Ack synchronizer:**
  - Two flops; `ack_s` is the second flop.
  - The FSM uses only `ack_s`.
  - The flops run regardless of `ena`.
- **FSM** (all transitions on a rising edge with `ena`=1; state and outputs hold while `ena`=0):
  - IDLE: if `level`≠0, go to HDR. Load `tx_data` = {`HDR_TAG`, 2'b00, head.tile} and set `tx_valid`=1.
  - HDR: if `ack_s`=1, go to HDR_WL and clear `tx_valid` (`tx_data` holds).
  - HDR_WL: if `ack_s`=0, go to DAT. Load `tx_data` = head.data and set `tx_valid`=1.
  - DAT: if `ack_s`=1, go to DAT_WL, clear `tx_valid`, and pop the FIFO head.
  - DAT_WL: if `ack_s`=0, go to IDLE.
- **Host rules:**
  - A byte is valid while `tx_valid`=1.
  - The host must raise ack only after seeing valid, and lower it only after seeing valid drop.
  - `tx_data` never changes while `tx_valid`=1.
- **Ordering:**
  - Strict FIFO.
  - The head entry is not popped until its data byte is acknowledged, so a frame always completes once started.
- **Simultaneous push and pop:** `level` is unchanged.
- **Pop while full:** `res_ready` is still 0 that cycle. Push resumes on the next cycle.
- **Pointers:** log2(DEPTH) bits, wrap modulo DEPTH. `level` is a separate counter.
- **`ena` low mid-frame:**
  - FSM, FIFO and `tx_*` freeze.
  - An ack edge that occurs meanwhile is observed via `ack_s` once `ena` returns.
- **Async reset mid-frame:** immediately drops `tx_valid` and discards all FIFO contents.

## Timing
- Push into an empty FIFO with the FSM in IDLE at edge E0:
  - `level`=1 after E0.
  - IDLE→HDR at E1.
  - `tx_valid`=1 after E1.
- Ack latency:
  - `host_ack` sampled at edge A.
  - `ack_s`=1 after A+1.
  - FSM reacts at A+2, so `tx_valid` falls after A+2.
  - Same 3-edge latency on the falling ack.
- Minimum frame: 1 edge (IDLE→HDR) + 4 × (2 sync + 1 react) = 13 edges, with the host acking instantly.
- Back-to-back frames pass through IDLE for exactly one cycle.
- `res_ready` and `level` reflect the registered count. No same-cycle bypass from `res_valid` to `tx_data`.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-frame (`tx_valid`=1, `level`=2) → outputs 0 immediately; after release, `level`=0 and `res_ready`=1.
- **Single frame:** push tile=2, data=0x5C; host acks each byte promptly → bytes observed are 0xA2 then 0x5C; `busy` returns to 0; `level` returns to 0; 13 edges minimum.
- **Fill and drain:**
  - Push 5 results on consecutive cycles with the host stalled: first 4 accepted, `res_ready`=0 on the 5th.
  - Release the host → frames emerge in push order; the 5th is accepted the cycle after the first pop.
- **Slow host:** hold ack low for 20 cycles after `tx_valid` rises → `tx_valid` and `tx_data` stay stable the whole time; no state change.
- **`ena` freeze:** drop `ena` while in DAT with `tx_data`=0x33 and toggle ack high → `tx_valid` stays 1. Raise `ena` → `tx_valid` drops 1 edge later (`ack_s` already 1).
- **Wrap-around:** stream 10 frames with tiles 0..3 cycling and data 0x00..0x09 → all headers and data correct across pointer wrap; `level` never exceeds 4.

Source files
------------

// File: rtl/cgra_result_tx_if.sv
// cgra_result_tx_if: result-push and host byte-handshake signals of the result transmitter
interface cgra_result_tx_if;
  logic       res_valid;
  logic [1:0] res_tile;
  logic [7:0] res_data;
  logic       res_ready;
  logic       host_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic [3:0] level;
  modport master (
    output res_valid, res_tile, res_data, host_ack,
    input  res_ready, tx_data, tx_valid, busy, level
  );
  modport slave (
    input  res_valid, res_tile, res_data, host_ack,
    output res_ready, tx_data, tx_valid, busy, level
  );
endinterface

// File: rtl/cgra_result_tx.sv
// cgra_result_tx: buffers array results and sends each as a header/data byte pair over a 4-phase host handshake
module cgra_result_tx #(
  parameter int         DEPTH   = 4,
  parameter logic [3:0] HDR_TAG = 4'b1010
) (
  input logic               clk,
  input logic               rst_n,
  input logic               ena,
  cgra_result_tx_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, HDR, HDR_WL, DAT, DAT_WL} state_t;
  state_t        state;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [3:0]    cnt;
  logic          ack_m, ack_s, push, pop;
  logic [9:0]    head;
  assign head          = mem[rp];
  assign bus.res_ready = ena & (cnt != 4'(DEPTH));
  assign bus.level     = cnt;
  assign push          = bus.res_valid & bus.res_ready;
  // the head leaves only once its data byte is acknowledged, so a started frame always completes
  assign pop           = ena & (state == DAT) & ack_s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= bus.host_ack;
      ack_s <= ack_m;
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {bus.res_tile, bus.res_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + 4'(push) - 4'(pop);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      bus.busy     <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: if (cnt != 4'd0) begin
          state        <= HDR;
          bus.tx_data  <= {HDR_TAG, 2'b00, head[9:8]};
          bus.tx_valid <= 1'b1;
          bus.busy     <= 1'b1;
        end
        HDR: if (ack_s) begin
          state        <= HDR_WL;
          bus.tx_valid <= 1'b0;
        end
        HDR_WL: if (!ack_s) begin
          state        <= DAT;
          bus.tx_data  <= head[7:0];
          bus.tx_valid <= 1'b1;
        end
        DAT: if (ack_s) begin
          state        <= DAT_WL;
          bus.tx_valid <= 1'b0;
        end
        DAT_WL: if (!ack_s) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cgra_result_tx.sv
// tb_cgra_result_tx: directed checks of buffering, framing, handshake latency, freeze and reset
module tb_cgra_result_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   max_lvl = 0;
  int   t0;
  logic stable;
  logic [7:0] b;
  cgra_result_tx_if bus();
  cgra_result_tx dut (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input logic v, input string tag);
    int n = 0;
    while (bus.tx_valid !== v && n < 200) begin
      tick();
      n++;
    end
    if (bus.tx_valid !== v) chk({tag, " timeout"}, 32'(bus.tx_valid), 32'(v));
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (bus.busy !== 1'b0) chk({tag, " idle timeout"}, 32'(bus.busy), 0);
  endtask
  task automatic recv_byte(input string tag, output logic [7:0] d);
    wait_valid(1'b1, {tag, " rise"});
    d = bus.tx_data;
    bus.host_ack = 1'b1;
    wait_valid(1'b0, {tag, " fall"});
    bus.host_ack = 1'b0;
  endtask
  task automatic recv_frame(input string tag, input logic [1:0] tile, input logic [7:0] data);
    logic [7:0] h, d;
    recv_byte(tag, h);
    chk({tag, " hdr"}, 32'(h), 32'({4'hA, 2'b00, tile}));
    recv_byte(tag, d);
    chk({tag, " data"}, 32'(d), 32'(data));
  endtask
  task automatic push(input logic [1:0] tile, input logic [7:0] data);
    bus.res_valid = 1'b1;
    bus.res_tile  = tile;
    bus.res_data  = data;
    tick();
    bus.res_valid = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.res_valid = 1'b0;
    bus.res_tile  = '0;
    bus.res_data  = '0;
    bus.host_ack  = 1'b0;
    repeat (2) tick();
    chk("rst tx_valid", 32'(bus.tx_valid), 0);
    chk("rst tx_data", 32'(bus.tx_data), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst level", 32'(bus.level), 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    #1;
    chk("rst ready", 32'(bus.res_ready), 1);
    tick();
    push(2'd1, 8'h11);
    push(2'd2, 8'h22);
    chk("mid tx_valid", 32'(bus.tx_valid), 1);
    chk("mid level", 32'(bus.level), 2);
    rst_n = 1'b0;
    #1;
    chk("async tx_valid", 32'(bus.tx_valid), 0);
    chk("async level", 32'(bus.level), 0);
    chk("async busy", 32'(bus.busy), 0);
    chk("async tx_data", 32'(bus.tx_data), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post level", 32'(bus.level), 0);
    chk("post ready", 32'(bus.res_ready), 1);
    chk("post tx_valid", 32'(bus.tx_valid), 0);
    push(2'd2, 8'h5C);
    t0 = cyc;
    recv_frame("single", 2'd2, 8'h5C);
    wait_idle("single");
    chk("single edges", 32'(cyc - t0), 13);
    chk("single level", 32'(bus.level), 0);
    for (int i = 0; i < 5; i++) begin
      bus.res_valid = 1'b1;
      bus.res_tile  = 2'(i % 4);
      bus.res_data  = 8'(8'h40 + i);
      chk("fill ready", 32'(bus.res_ready), (i < 4) ? 1 : 0);
      tick();
    end
    chk("fill level", 32'(bus.level), 4);
    recv_byte("fill0", b);
    chk("fill0 hdr", 32'(b), 32'h00A0);
    recv_byte("fill0", b);
    chk("fill0 data", 32'(b), 32'h0040);
    chk("pop ready", 32'(bus.res_ready), 1);
    chk("pop level", 32'(bus.level), 3);
    tick();
    bus.res_valid = 1'b0;
    chk("refill level", 32'(bus.level), 4);
    for (int i = 1; i < 5; i++) recv_frame("drain", 2'(i % 4), 8'(8'h40 + i));
    wait_idle("drain");
    chk("drain level", 32'(bus.level), 0);
    push(2'd3, 8'h77);
    wait_valid(1'b1, "slow");
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA3 || bus.busy !== 1'b1) stable = 1'b0;
    end
    chk("slow stable", 32'(stable), 1);
    recv_frame("slow", 2'd3, 8'h77);
    wait_idle("slow");
    push(2'd1, 8'h33);
    recv_byte("frz", b);
    chk("frz hdr", 32'(b), 32'h00A1);
    wait_valid(1'b1, "frz dat");
    chk("frz data", 32'(bus.tx_data), 32'h33);
    ena = 1'b0;
    bus.host_ack = 1'b1;
    repeat (4) tick();
    chk("frz held valid", 32'(bus.tx_valid), 1);
    chk("frz held data", 32'(bus.tx_data), 32'h33);
    chk("frz ready", 32'(bus.res_ready), 0);
    chk("frz level", 32'(bus.level), 1);
    ena = 1'b1;
    tick();
    chk("frz resume", 32'(bus.tx_valid), 0);
    chk("frz popped", 32'(bus.level), 0);
    bus.host_ack = 1'b0;
    wait_idle("frz");
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic acc;
          int n;
          bus.res_valid = 1'b1;
          bus.res_tile  = 2'(i % 4);
          bus.res_data  = 8'(i);
          n = 0;
          do begin
            acc = bus.res_ready;
            tick();
            n++;
          end while (!acc && n < 400);
          if (!acc) chk("wrap push timeout", 32'(acc), 1);
        end
        bus.res_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 10; i++) recv_frame("wrap", 2'(i % 4), 8'(i));
      end
    join
    wait_idle("wrap");
    chk("wrap level", 32'(bus.level), 0);
    chk("wrap max level", 32'(max_lvl), 4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
